// File: rtl/multicycle_fsm.sv
// Main sequencing FSM for the multicycle MIPS core.
// Steps the shared datapath one state per clock, stretched by memready.
module multicycle_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       memready,
  output logic       memreq,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  state_t cur, nxt;

  logic is_lw, is_sw, is_rtype;
  logic is_beq, is_addi, is_j;

  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_rtype = (op == OP_RTYPE);
  assign is_beq   = (op == OP_BEQ);
  assign is_addi  = (op == OP_ADDI);
  assign is_j     = (op == OP_J);

  logic memreq_r, memwrite_r, irwrite_r;
  logic pcwrite_r, branch_r, regwrite_r;
  logic illegal_r;

  always_ff @(posedge clk) begin
    if (reset) cur <= FETCH;
    else       cur <= nxt;
  end

  always_comb begin
    nxt        = FETCH;
    memreq_r   = 1'b0;
    memwrite_r = 1'b0;
    irwrite_r  = 1'b0;
    pcwrite_r  = 1'b0;
    branch_r   = 1'b0;
    regwrite_r = 1'b0;
    illegal_r  = 1'b0;
    iord       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    pcsrc      = 2'b00;
    case (cur)
      FETCH: begin
        memreq_r  = 1'b1;
        alusrcb   = 2'b01;
        irwrite_r = memready;
        pcwrite_r = memready;
        nxt       = memready ? DECODE : FETCH;
      end
      DECODE: begin
        // branch target computed early into ALUOut
        alusrcb = 2'b11;
        unique case (1'b1)
          is_lw,
          is_sw:    nxt = MEMADR;
          is_rtype: nxt = EXECUTE;
          is_beq:   nxt = BRANCH;
          is_addi:  nxt = ADDIEXEC;
          is_j:     nxt = JUMP;
          default: begin
            nxt       = FETCH;
            illegal_r = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        nxt     = is_sw ? MEMWR : MEMRD;
      end
      MEMRD: begin
        memreq_r = 1'b1;
        iord     = 1'b1;
        nxt      = memready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        regwrite_r = 1'b1;
        memtoreg   = 1'b1;
        nxt        = FETCH;
      end
      MEMWR: begin
        memreq_r   = 1'b1;
        memwrite_r = 1'b1;
        iord       = 1'b1;
        nxt        = memready ? FETCH : MEMWR;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        nxt     = ALUWB;
      end
      ALUWB: begin
        regwrite_r = 1'b1;
        regdst     = 1'b1;
        nxt        = FETCH;
      end
      BRANCH: begin
        alusrca  = 1'b1;
        aluop    = 2'b01;
        pcsrc    = 2'b01;
        branch_r = 1'b1;
        nxt      = FETCH;
      end
      ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        nxt     = ADDIWB;
      end
      ADDIWB: begin
        regwrite_r = 1'b1;
        nxt        = FETCH;
      end
      JUMP: begin
        pcsrc     = 2'b10;
        pcwrite_r = 1'b1;
        nxt       = FETCH;
      end
      default: nxt = FETCH;
    endcase
  end

  // strobes are masked while reset is held
  assign memreq     = memreq_r   & ~reset;
  assign memwrite   = memwrite_r & ~reset;
  assign irwrite    = irwrite_r  & ~reset;
  assign pcwrite    = pcwrite_r  & ~reset;
  assign branch     = branch_r   & ~reset;
  assign regwrite   = regwrite_r & ~reset;
  assign illegal_op = illegal_r  & ~reset;
  assign state      = cur;

endmodule

// File: tb/tb_multicycle_fsm.sv
// Bench for multicycle_fsm: directed vector table then
// randomized run against a path-queue reference model.
module tb_multicycle_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       memready;
  logic       memreq, memwrite, iord, irwrite;
  logic       pcwrite, branch, regwrite, regdst;
  logic       memtoreg, alusrca, illegal_op;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic [3:0] st;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011;
  localparam logic [5:0] RT = 6'b000000;
  localparam logic [5:0] BQ = 6'b000100;
  localparam logic [5:0] AI = 6'b001000;
  localparam logic [5:0] JJ = 6'b000010;
  localparam logic [5:0] BAD = 6'b111111;

  always #5 clk = ~clk;

  multicycle_fsm dut (
    .clk(clk), .reset(reset), .op(op),
    .memready(memready), .memreq(memreq),
    .memwrite(memwrite), .iord(iord),
    .irwrite(irwrite), .pcwrite(pcwrite),
    .branch(branch), .regwrite(regwrite),
    .regdst(regdst), .memtoreg(memtoreg),
    .alusrca(alusrca), .alusrcb(alusrcb),
    .aluop(aluop), .pcsrc(pcsrc),
    .illegal_op(illegal_op), .state(st)
  );

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       mr;
    logic [3:0] st;
    logic [7:0] stb;
    logic [5:0] ctl;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [5:0] o,
                     input logic m, input logic [3:0] s,
                     input logic [7:0] sb, input logic [5:0] c);
    vec_t v;
    v.rst = r; v.op = o; v.mr = m;
    v.st = s; v.stb = sb; v.ctl = c;
    vecs.push_back(v);
  endtask

  function automatic logic [7:0] got_stb();
    return {memreq, memwrite, iord, irwrite,
            pcwrite, branch, regwrite, illegal_op};
  endfunction

  function automatic logic [21:0] got_all();
    return {got_stb(), regdst, memtoreg, alusrca,
            alusrcb, aluop, pcsrc, st};
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t",
               name, got, exp, $time);
    end
  endtask

  // Reference: expected control word from the instruction step in flight
  function automatic logic [21:0] model_word(
      input int s, input logic [5:0] o,
      input logic m, input logic r);
    logic rq, mw, io, irw, pcw, br, rw, il;
    logic rd, mt, sa;
    logic [1:0] sb, ao, ps;
    logic legal;
    {rq, mw, io, irw, pcw, br, rw, il} = '0;
    {rd, mt, sa} = '0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    legal = (o == LW) || (o == SW) || (o == RT) ||
            (o == BQ) || (o == AI) || (o == JJ);
    case (s)
      0:  begin rq = 1; sb = 2'b01; irw = m; pcw = m; end
      1:  begin sb = 2'b11; il = !legal; end
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin rq = 1; io = 1; end
      4:  begin rw = 1; mt = 1; end
      5:  begin rq = 1; io = 1; mw = 1; end
      6:  begin sa = 1; ao = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; ao = 2'b01; ps = 2'b01; br = 1; end
      9:  begin sa = 1; sb = 2'b10; end
      10: begin rw = 1; end
      11: begin ps = 2'b10; pcw = 1; end
      default: ;
    endcase
    if (r) {rq, mw, irw, pcw, br, rw, il} = '0;
    return {rq, mw, io, irw, pcw, br, rw, il,
            rd, mt, sa, sb, ao, ps, s[3:0]};
  endfunction

  int       cur;
  int       plan[$];
  logic [5:0] dec_op;

  task automatic model_step(input logic r, input logic [5:0] o,
                            input logic m);
    if (r) begin
      cur = 0;
      plan.delete();
    end else if ((cur == 0 || cur == 3 || cur == 5) && !m) begin
      cur = cur;
    end else if (cur == 0) begin
      cur = 1;
    end else begin
      if (cur == 1) begin
        dec_op = o;
        case (o)
          LW: plan = '{2, 3, 4};
          SW: plan = '{2, 5};
          RT: plan = '{6, 7};
          BQ: plan = '{8};
          AI: plan = '{9, 10};
          JJ: plan = '{11};
          default: plan.delete();
        endcase
      end
      cur = (plan.size() != 0) ? plan.pop_front() : 0;
    end
  endtask

  function automatic logic [5:0] rand_op();
    case ($urandom_range(0, 7))
      0: return LW;
      1: return SW;
      2: return RT;
      3: return BQ;
      4: return AI;
      5: return JJ;
      default: return 6'($urandom);
    endcase
  endfunction

  initial begin
    reset = 1; op = RT; memready = 1;
    // reach EXECUTE before the reset rows
    add(0, LW, 1, 0, 8'b1001_1000, 6'b01_00_00);
    add(0, LW, 1, 1, 8'b0000_0000, 6'b11_00_00);
    add(0, LW, 1, 2, 8'b0000_0000, 6'b10_00_00);
    add(0, LW, 1, 3, 8'b1010_0000, 6'b00_00_00);
    add(0, LW, 1, 4, 8'b0000_0010, 6'b00_00_00);
    add(0, SW, 0, 0, 8'b1000_0000, 6'b01_00_00);
    add(0, SW, 0, 0, 8'b1000_0000, 6'b01_00_00);
    add(0, SW, 1, 0, 8'b1001_1000, 6'b01_00_00);
    add(0, SW, 1, 1, 8'b0000_0000, 6'b11_00_00);
    add(0, SW, 1, 2, 8'b0000_0000, 6'b10_00_00);
    add(0, SW, 0, 5, 8'b1110_0000, 6'b00_00_00);
    add(0, SW, 0, 5, 8'b1110_0000, 6'b00_00_00);
    add(0, SW, 0, 5, 8'b1110_0000, 6'b00_00_00);
    add(0, SW, 1, 5, 8'b1110_0000, 6'b00_00_00);
    add(0, RT, 1, 0, 8'b1001_1000, 6'b01_00_00);
    add(0, RT, 1, 1, 8'b0000_0000, 6'b11_00_00);
    add(0, BQ, 1, 6, 8'b0000_0000, 6'b00_10_00);
    add(0, BQ, 1, 7, 8'b0000_0010, 6'b00_00_00);
    add(0, BQ, 1, 0, 8'b1001_1000, 6'b01_00_00);
    add(0, BQ, 1, 1, 8'b0000_0000, 6'b11_00_00);
    add(0, LW, 1, 8, 8'b0000_0100, 6'b00_01_01);
    add(0, BAD, 1, 0, 8'b1001_1000, 6'b01_00_00);
    add(0, BAD, 1, 1, 8'b0000_0001, 6'b11_00_00);
    add(0, JJ, 1, 0, 8'b1001_1000, 6'b01_00_00);
    add(0, JJ, 1, 1, 8'b0000_0000, 6'b11_00_00);
    add(0, JJ, 1, 11, 8'b0000_1000, 6'b00_00_10);
    add(0, RT, 1, 0, 8'b1001_1000, 6'b01_00_00);
    add(0, RT, 1, 1, 8'b0000_0000, 6'b11_00_00);
    add(1, RT, 1, 6, 8'b0000_0000, 6'b00_10_00);
    add(1, RT, 1, 0, 8'b0000_0000, 6'b01_00_00);
    add(0, RT, 1, 0, 8'b1001_1000, 6'b01_00_00);
    add(0, RT, 1, 1, 8'b0000_0000, 6'b11_00_00);

    @(posedge clk);
    @(posedge clk);
    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst;
      op = vecs[i].op;
      memready = vecs[i].mr;
      #1;
      chk($sformatf("vec%0d_state", i), 32'(st), 32'(vecs[i].st));
      chk($sformatf("vec%0d_strobes", i),
          32'(got_stb()), 32'(vecs[i].stb));
      chk($sformatf("vec%0d_ctl", i),
          32'({alusrcb, aluop, pcsrc}), 32'(vecs[i].ctl));
      @(posedge clk);
    end

    // random run: model restarts from reset
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    cur = 0;
    plan.delete();
    dec_op = LW;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 39) == 0);
      memready = ($urandom_range(0, 9) < 7);
      op = (cur == 2) ? dec_op : rand_op();
      #1;
      chk("random_word", 32'(got_all()),
          32'(model_word(cur, op, memready, reset)));
      @(posedge clk);
      model_step(reset, op, memready);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_fsm.md
# multicycle_fsm

Main sequencing state machine for the multicycle MIPS core. It decodes the 6-bit opcode of the instruction register and steps the shared datapath (single unified memory, single ALU) through fetch, decode, execute, memory and writeback cycles, one state per clock. A memory-ready handshake stretches the memory states for slow memories. It sits inside the controller, beside the ALU decoder, and drives all datapath multiplexer selects and write enables.

## Interface
- No parameters; all widths are fixed by the MIPS ISA.
- clk  input  1  core clock; all state changes on rising edge
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high
- op  input  6  opcode field instr[31:26] from the instruction register
- memready  input  1  memory completes the current access this cycle
- memreq  output  1  memory access requested this cycle
- memwrite  output  1  memory write strobe
- iord  output  1  0 = PC addresses memory, 1 = ALUOut addresses memory
- irwrite  output  1  load instruction register
- pcwrite  output  1  unconditional PC load
- branch  output  1  PC load qualified by ALU zero (external AND/OR)
- regwrite  output  1  register file write enable
- regdst  output  1  0 = rt, 1 = rd destination
- memtoreg  output  1  0 = ALUOut, 1 = data register to register file
- alusrca  output  1  0 = PC, 1 = register A
- alusrcb  output  2  00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2
- aluop  output  2  00 = add, 01 = subtract, 10 = use funct
- pcsrc  output  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
- illegal_op  output  1  one-cycle pulse: unsupported opcode seen in DECODE
- state  output  4  current state encoding, for debug

## Operation
- Opcodes: LW 100011, SW 101011, RTYPE 000000, BEQ 000100, ADDI 001000, J 000010.
- States/encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11. Encodings 12-15 unreachable; if entered, next state is FETCH.
- Every output not listed for a state is 0 (including 2-bit fields = 00).
- FETCH: memreq=1, alusrcb=01; irwrite=pcwrite=memready. Stay while memready=0; go DECODE when 1.
- DECODE: alusrcb=11 (branch target into ALUOut). LW/SW -> MEMADR, RTYPE -> EXECUTE, BEQ -> BRANCH, ADDI -> ADDIEXEC, J -> JUMP, other -> FETCH with illegal_op=1.
- MEMADR: alusrca=1, alusrcb=10. LW -> MEMRD, SW -> MEMWR.
- MEMRD: memreq=1, iord=1. Stay while memready=0; -> MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0 -> FETCH.
- MEMWR: memreq=1, iord=1, memwrite=1 (held for whole wait). Stay while memready=0; -> FETCH.
- EXECUTE: alusrca=1, alusrcb=00, aluop=10 -> ALUWB.
- ALUWB: regwrite=1, regdst=1 -> FETCH.
- BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1 -> FETCH.
- ADDIEXEC: alusrca=1, alusrcb=10 -> ADDIWB.
- ADDIWB: regwrite=1, regdst=0 -> FETCH.
- JUMP: pcsrc=10, pcwrite=1 -> FETCH.
- op sampled only in DECODE and MEMADR; changes in other states ignored.

## Timing
- Moore outputs decoded from state register, except irwrite/pcwrite in FETCH (qualified by memready, combinational).
- Rising edge with reset=1: state <= FETCH regardless of current state, including mid-wait in MEMRD/MEMWR.
- While reset=1: memreq, memwrite, irwrite, pcwrite, branch, regwrite, illegal_op forced 0 (combinational gate); state output reads 0 after first reset edge.
- Cycle counts with memready held 1: LW 5, SW 4, RTYPE 4, ADDI 4, BEQ 3, J 3, illegal 2.
- Each memready=0 cycle in FETCH/MEMRD/MEMWR adds exactly one cycle; no other state waits.
- memready while memreq=0 is ignored.
- irwrite and pcwrite in FETCH pulse exactly one cycle per fetch.

## Test plan
- Reset: assert reset 2 cycles from state 6 -> state=0, all strobes 0 during reset; first cycle after release memreq=1, alusrcb=01.
- LW, memready=1: states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in cycle 5; iord=1 only in cycle 4.
- SW, memready low 3 cycles in MEMWR: state 5 held 4 cycles, memwrite=1 all 4, then FETCH; no regwrite.
- RTYPE then BEQ back-to-back: states 0,1,6,7,0,1,8,0; aluop=10 in 6, aluop=01/pcsrc=01/branch=1 in 8.
- FETCH with memready 0,0,1: state 0 for 3 cycles, irwrite=pcwrite=1 only in third, then DECODE.
- op=111111 in DECODE -> illegal_op=1 one cycle, next state 0; J -> pcsrc=10, pcwrite=1 in state 11.
